// File: rtl/eq_audio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eq_audio_pkg
// Purpose  : Shared sample width, slot width and I2S word-select polarity.
// Revision : 1.0 - initial release
// ============================================================================
package eq_audio_pkg;

   localparam int   c_sample_bits = 16;
   localparam int   c_slot_bits   = 32;

   localparam logic c_lrclk_left  = 1'b0;
   localparam logic c_lrclk_right = 1'b1;

   typedef logic signed [c_sample_bits-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/i2s_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : i2s_clk_gen
// Purpose  : bclk divider, frame bit counter, lrclk and falling-edge strobes.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_clk_gen
   import eq_audio_pkg::*;
#(
   parameter int SLOT_BITS = c_slot_bits,
   parameter int BCLK_DIV  = 2,
   parameter int DIV_BITS  = $clog2(BCLK_DIV + 1),
   parameter int CNT_BITS  = $clog2(2 * SLOT_BITS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   output logic                bclk,
   output logic                lrclk,
   output logic                fall_evt,
   output logic                frame_evt,
   output logic [CNT_BITS-1:0] slot_pos
);

   localparam logic [DIV_BITS-1:0] c_div_last = DIV_BITS'(BCLK_DIV - 1);
   localparam logic [CNT_BITS-1:0] c_cnt_last = CNT_BITS'(2 * SLOT_BITS - 1);
   localparam logic [CNT_BITS-1:0] c_slot     = CNT_BITS'(SLOT_BITS);

   logic [DIV_BITS-1:0] div_q;
   logic [DIV_BITS-1:0] div_d;
   logic                bclk_q;
   logic                bclk_d;
   logic [CNT_BITS-1:0] bit_cnt_q;
   logic [CNT_BITS-1:0] bit_cnt_d;
   logic                lrclk_q;
   logic                lrclk_d;
   logic                wrap;

   always_comb begin
      div_d     = div_q;
      bclk_d    = bclk_q;
      bit_cnt_d = bit_cnt_q;
      lrclk_d   = lrclk_q;
      wrap      = enable && (div_q == c_div_last);
      fall_evt  = wrap && bclk_q;

      if (enable) begin
         div_d = wrap ? '0 : div_q + 1'b1;
      end
      if (wrap) begin
         bclk_d = ~bclk_q;
      end
      if (fall_evt) begin
         bit_cnt_d = (bit_cnt_q == c_cnt_last) ? '0 : bit_cnt_q + 1'b1;
         if (bit_cnt_d == '0) begin
            lrclk_d = c_lrclk_left;
         end else if (bit_cnt_d == c_slot) begin
            lrclk_d = c_lrclk_right;
         end
      end

      // Position inside the current slot, for the bit that is about to be driven
      frame_evt = fall_evt && (bit_cnt_d == '0);
      slot_pos  = (bit_cnt_d >= c_slot) ? bit_cnt_d - c_slot : bit_cnt_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q     <= '0;
         bclk_q    <= 1'b0;
         bit_cnt_q <= c_cnt_last;
         lrclk_q   <= c_lrclk_right;
      end else begin
         div_q     <= div_d;
         bclk_q    <= bclk_d;
         bit_cnt_q <= bit_cnt_d;
         lrclk_q   <= lrclk_d;
      end
   end

   assign bclk  = bclk_q;
   assign lrclk = lrclk_q;

endmodule
`default_nettype wire

// File: rtl/eq_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : eq_i2s_tx
// Purpose  : Mono sample to I2S serializer with one-entry holding register.
// Revision : 1.0 - initial release
// ============================================================================
module eq_i2s_tx
   import eq_audio_pkg::*;
#(
   parameter int SAMPLE_BITS = c_sample_bits,
   parameter int SLOT_BITS   = c_slot_bits,
   parameter int BCLK_DIV    = 2,
   parameter int DIV_BITS    = $clog2(BCLK_DIV + 1),
   parameter int CNT_BITS    = $clog2(2 * SLOT_BITS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic signed [SAMPLE_BITS-1:0] in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          bclk,
   output logic                          lrclk,
   output logic                          sdata,
   output logic                          frame_start,
   output logic                          underrun
);

   localparam logic [CNT_BITS-1:0] c_msb_pos = CNT_BITS'(SAMPLE_BITS);

   logic                   fall_evt;
   logic                   frame_evt;
   logic [CNT_BITS-1:0]    slot_pos;

   logic [SAMPLE_BITS-1:0] hold_q;
   logic [SAMPLE_BITS-1:0] hold_d;
   logic                   hold_full_q;
   logic                   hold_full_d;
   logic [SAMPLE_BITS-1:0] tx_word_q;
   logic [SAMPLE_BITS-1:0] tx_word_d;
   logic                   sdata_q;
   logic                   sdata_d;
   logic                   frame_start_q;
   logic                   frame_start_d;
   logic                   underrun_q;
   logic                   underrun_d;
   logic                   accept;
   logic [SAMPLE_BITS-1:0] shifted;

   i2s_clk_gen #(
      .SLOT_BITS (SLOT_BITS),
      .BCLK_DIV  (BCLK_DIV),
      .DIV_BITS  (DIV_BITS),
      .CNT_BITS  (CNT_BITS)
   ) u_clk_gen (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .bclk      (bclk),
      .lrclk     (lrclk),
      .fall_evt  (fall_evt),
      .frame_evt (frame_evt),
      .slot_pos  (slot_pos)
   );

   always_comb begin
      accept        = in_valid && !hold_full_q;
      hold_d        = accept ? in_data : hold_q;
      hold_full_d   = hold_full_q;
      tx_word_d     = tx_word_q;
      sdata_d       = sdata_q;
      frame_start_d = frame_evt;
      underrun_d    = frame_evt && !hold_full_q;

      if (frame_evt) begin
         tx_word_d   = hold_full_q ? hold_q : '0;
         hold_full_d = 1'b0;
      end
      if (accept) begin
         hold_full_d = 1'b1;
      end

      // Slot position p carries word bit SAMPLE_BITS-p; p=0 is the I2S delay bit
      shifted = tx_word_q >> (c_msb_pos - slot_pos);
      if (fall_evt) begin
         sdata_d = (slot_pos != '0 && slot_pos <= c_msb_pos) ? shifted[0] : 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         tx_word_q     <= '0;
         sdata_q       <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
         tx_word_q     <= tx_word_d;
         sdata_q       <= sdata_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

   assign in_ready    = !hold_full_q;
   assign sdata       = sdata_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;

endmodule
`default_nettype wire
